// File: rtl/fir_coeff_ctrl_if.sv
// Host configuration, sample stream and coefficient bus of the FIR
// coefficient controller, grouped into one interface.
// The slave modport is the controller; the master modport is the host/stream side.
// Readback signals exist only when FIR_COEFF_READBACK_EN is defined.
interface fir_coeff_ctrl_if #(
  parameter int TAPS = 4,
  parameter int CW   = 16
);
  logic                   cfg_wr;
  logic [3:0]             cfg_addr;
  logic signed [CW-1:0]   cfg_data;
  logic                   cfg_commit;
  logic                   cfg_busy;
  logic                   cfg_err;
  logic                   swap_done;
  logic                   s_valid;
  logic signed [15:0]     s_data;
  logic                   s_ready;
  logic                   fir_sample_valid;
  logic signed [15:0]     fir_sample;
  logic [TAPS*CW-1:0]     coeff_bus;
  logic                   coeff_settled;
`ifdef FIR_COEFF_READBACK_EN
  logic                   cfg_rd;
  logic                   cfg_rbank;
  logic                   cfg_rvalid;
  logic signed [CW-1:0]   cfg_rdata;
`endif

  modport slave (
    input  cfg_wr, cfg_addr, cfg_data, cfg_commit, s_valid, s_data,
    output cfg_busy, cfg_err, swap_done, s_ready, fir_sample_valid, fir_sample,
    output coeff_bus, coeff_settled
`ifdef FIR_COEFF_READBACK_EN
    , input cfg_rd, cfg_rbank
    , output cfg_rvalid, cfg_rdata
`endif
  );

  modport master (
    output cfg_wr, cfg_addr, cfg_data, cfg_commit, s_valid, s_data,
    input  cfg_busy, cfg_err, swap_done, s_ready, fir_sample_valid, fir_sample,
    input  coeff_bus, coeff_settled
`ifdef FIR_COEFF_READBACK_EN
    , output cfg_rd, cfg_rbank
    , input cfg_rvalid, cfg_rdata
`endif
  );
endinterface

// File: rtl/fir_coeff_ctrl.sv
// FIR coefficient controller: double-buffered coefficient bank (shadow/active),
// one-cycle atomic swap that stalls the sample stream, and post-swap settling
// tracking (TAPS accepted samples before coeff_settled rises).
// Optional macro FIR_COEFF_READBACK_EN adds a registered shadow/active readback port.
module fir_coeff_ctrl #(
  parameter int                     TAPS       = 4,
  parameter int                     CW         = 16,
  parameter logic signed [CW-1:0]   COEFF_INIT = 16'sh2000
) (
  input  logic             clk,
  input  logic             rst,
  fir_coeff_ctrl_if.slave  bus
);
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SWAP   = 2'd2;

  localparam int               CNT_W  = 5;
  localparam logic [CNT_W-1:0] TAPS_C = CNT_W'(TAPS);

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic signed [CW-1:0] shadow_q [TAPS];
  logic signed [CW-1:0] active_q [TAPS];
  logic                 err_q, err_d;
  logic                 swap_done_q;

  logic in_swap;
  logic addr_ok;
  logic accept;
  logic wr_ok;

  assign in_swap = (state_q == ST_SWAP);
  assign addr_ok = ({1'b0, bus.cfg_addr} < TAPS_C);
  assign accept  = bus.s_valid && !in_swap;
  // A write in the same cycle as a commit still lands: the copy happens one edge later.
  assign wr_ok   = bus.cfg_wr && addr_ok && !in_swap;

  assign bus.s_ready          = !in_swap;
  assign bus.fir_sample_valid = accept;
  assign bus.fir_sample       = bus.s_data;
  assign bus.cfg_busy         = in_swap;
  assign bus.cfg_err          = err_q;
  assign bus.swap_done        = swap_done_q;
  assign bus.coeff_settled    = (state_q == ST_RUN);

  for (genvar g = 0; g < TAPS; g++) begin : g_bus
    assign bus.coeff_bus[g*CW +: CW] = active_q[g];
  end

  // Next-state logic: commit wins over settle counting; SWAP always lasts one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SWAP: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
      ST_SETTLE: begin
        if (bus.cfg_commit) begin
          state_d = ST_SWAP;
        end else if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == TAPS_C) state_d = ST_RUN;
        end
      end
      default: begin
        state_d = bus.cfg_commit ? ST_SWAP : ST_RUN;
      end
    endcase
  end

  // Rejected writes (and, with readback, out-of-range reads) flag an error next cycle.
  always_comb begin
    err_d = bus.cfg_wr && !wr_ok;
`ifdef FIR_COEFF_READBACK_EN
    if (bus.cfg_rd && !addr_ok) err_d = 1'b1;
`endif
  end

  // Control registers: state, settle counter, error and swap-done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SETTLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      swap_done_q <= in_swap;
    end
  end

  // Coefficient banks: shadow takes host writes, active copies shadow on the SWAP exit edge.
  always_ff @(posedge clk) begin
    for (int k = 0; k < TAPS; k++) begin
      if (rst) begin
        shadow_q[k] <= COEFF_INIT;
        active_q[k] <= COEFF_INIT;
      end else begin
        if (wr_ok && ({1'b0, bus.cfg_addr} == CNT_W'(k))) shadow_q[k] <= bus.cfg_data;
        if (in_swap) active_q[k] <= shadow_q[k];
      end
    end
  end

`ifdef FIR_COEFF_READBACK_EN
  logic signed [CW-1:0] rd_sel;
  logic                 rvalid_q;
  logic signed [CW-1:0] rdata_q;

  // Readback mux; an out-of-range index matches no entry and reads as zero.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < TAPS; k++) begin
      if ({1'b0, bus.cfg_addr} == CNT_W'(k)) rd_sel = bus.cfg_rbank ? active_q[k] : shadow_q[k];
    end
  end

  // Registered read response, one cycle after cfg_rd, allowed in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= bus.cfg_rd;
      if (bus.cfg_rd) rdata_q <= rd_sel;
    end
  end

  assign bus.cfg_rvalid = rvalid_q;
  assign bus.cfg_rdata  = rdata_q;
`endif
endmodule
